// File: rtl/qspi_arb_pkg.sv
// Shared definitions for the QSPI line-transfer arbiter: default geometry,
// FSM state encoding and a small state classification helper.
package qspi_arb_pkg;

    localparam int QSPI_PA          = 22;
    localparam int QSPI_LINE_LENGTH = 4;
    localparam int QSPI_TIMEOUT     = 255;
    localparam int TAGW             = QSPI_PA - $clog2(QSPI_LINE_LENGTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_FILL = 3'd1,
        ST_D_PUSH = 3'd2,
        ST_D_PULL = 3'd3,
        ST_GAP    = 3'd4
    } arb_state_e;

    function automatic logic is_busy(input arb_state_e st);
        return (st == ST_I_FILL) || (st == ST_D_PUSH) || (st == ST_D_PULL);
    endfunction

endpackage

// File: rtl/qspi_arb_wdog.sv
// Transfer watchdog: loaded at grant, counts granted cycles and flags expiry
// when the count of granted cycles reaches TIMEOUT.
module qspi_arb_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The first granted cycle already counts as cycle 1, so the load value is 1.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = ONE;
        end else if (run_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + ONE;
        end else if (!run_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = run_i && (cnt_q == LIMIT);

endmodule

// File: rtl/qspi_arb.sv
// Arbitrates the QSPI line engine between I-cache fill, D-cache writeback and
// D-cache fill; latches the winner, steers strobes back and guards with a watchdog.
module qspi_arb
    import qspi_arb_pkg::*;
#(
    parameter int PA          = QSPI_PA,
    parameter int LINE_LENGTH = QSPI_LINE_LENGTH,
    parameter int TIMEOUT     = QSPI_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            rom_enable,
    input  logic                            i_req,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0] i_tag,
    input  logic                            d_push,
    input  logic                            d_pull,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0] d_tag,
    output logic                            mem_req,
    output logic                            mem_i_d,
    output logic                            mem_mem,
    output logic                            mem_write,
    output logic [PA-$clog2(LINE_LENGTH)-1:0] mem_paddr,
    input  logic                            mem_done,
    input  logic                            q_wstrobe_i,
    input  logic                            q_wstrobe_d,
    input  logic                            q_rstrobe_d,
    output logic                            i_wstrobe,
    output logic                            d_wstrobe,
    output logic                            d_rstrobe,
    output logic                            i_done,
    output logic                            d_done,
    output logic                            timeout_err
);

    localparam int TW = PA - $clog2(LINE_LENGTH);

    arb_state_e    state_q, state_d, grant_s;
    logic          mem_req_q, mem_req_d;
    logic          mem_i_d_q, mem_i_d_d;
    logic          mem_mem_q, mem_mem_d;
    logic          mem_write_q, mem_write_d;
    logic [TW-1:0] mem_paddr_q, mem_paddr_d;
    logic          last_d_q, last_d_d;
    logic          d_lock_q, d_lock_d;
    logic          busy_s, expire_s, end_s, load_s;

    assign busy_s = is_busy(state_q);
    assign load_s = (state_q == ST_IDLE) && (grant_s != ST_IDLE);
    assign end_s  = busy_s && (mem_done || expire_s);

    qspi_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst_n    (reset),
        .load_i   (load_s),
        .run_i    (busy_s),
        .expire_o (expire_s)
    );

    // Owner selection: a pending refill after our own writeback wins outright,
    // otherwise D and I alternate on last_d and writeback beats refill.
    always_comb begin
        grant_s = ST_IDLE;
        if (d_lock_q && d_pull) begin
            grant_s = ST_D_PULL;
        end else if ((d_push || d_pull) && !(i_req && last_d_q)) begin
            grant_s = d_push ? ST_D_PUSH : ST_D_PULL;
        end else if (i_req) begin
            grant_s = ST_I_FILL;
        end else begin
            grant_s = ST_IDLE;
        end
    end

    // Next-state, grant latching and completion bookkeeping.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_i_d_d   = mem_i_d_q;
        mem_mem_d   = mem_mem_q;
        mem_write_d = mem_write_q;
        mem_paddr_d = mem_paddr_q;
        last_d_d    = last_d_q;
        d_lock_d    = d_lock_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s != ST_IDLE) begin
                    state_d     = grant_s;
                    mem_req_d   = 1'b1;
                    mem_i_d_d   = (grant_s == ST_I_FILL);
                    mem_write_d = (grant_s == ST_D_PUSH);
                    mem_mem_d   = (grant_s == ST_D_PUSH) ? 1'b0 : rom_enable;
                    mem_paddr_d = (grant_s == ST_I_FILL) ? i_tag : d_tag;
                    d_lock_d    = (grant_s == ST_D_PUSH) ? d_lock_q : 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_I_FILL, ST_D_PUSH, ST_D_PULL: begin
                if (end_s) begin
                    state_d   = ST_GAP;
                    mem_req_d = 1'b0;
                    last_d_d  = (state_q != ST_I_FILL);
                    d_lock_d  = (state_q == ST_D_PUSH) ? 1'b1 : d_lock_q;
                end else begin
                    state_d = state_q;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and latched transaction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_i_d_q   <= 1'b0;
            mem_mem_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_paddr_q <= '0;
            last_d_q    <= 1'b0;
            d_lock_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_i_d_q   <= mem_i_d_d;
            mem_mem_q   <= mem_mem_d;
            mem_write_q <= mem_write_d;
            mem_paddr_q <= mem_paddr_d;
            last_d_q    <= last_d_d;
            d_lock_q    <= d_lock_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_i_d   = mem_i_d_q;
    assign mem_mem   = mem_mem_q;
    assign mem_write = mem_write_q;
    assign mem_paddr = mem_paddr_q;

    // Strobes and dones are state-gated so anything outside a transfer is dropped.
    assign i_wstrobe   = (state_q == ST_I_FILL) && q_wstrobe_i;
    assign d_wstrobe   = (state_q == ST_D_PULL) && q_wstrobe_d;
    assign d_rstrobe   = (state_q == ST_D_PUSH) && q_rstrobe_d;
    assign i_done      = (state_q == ST_I_FILL) && end_s;
    assign d_done      = ((state_q == ST_D_PUSH) || (state_q == ST_D_PULL)) && end_s;
    assign timeout_err = expire_s && !mem_done;

endmodule

// File: tb/tb_qspi_arb.sv
// Self-checking bench for qspi_arb: directed scenarios plus randomized traffic
// compared against a transaction-level model of the arbitration rules.
module tb_qspi_arb;

    localparam int TW       = 20;
    localparam int TMO      = 255;
    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_PUSH = 2;
    localparam int OWN_PULL = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rom_enable = 1'b0;
    logic          i_req = 1'b0;
    logic [TW-1:0] i_tag = '0;
    logic          d_push = 1'b0;
    logic          d_pull = 1'b0;
    logic [TW-1:0] d_tag = '0;
    logic          mem_req, mem_i_d, mem_mem, mem_write;
    logic [TW-1:0] mem_paddr;
    logic          mem_done = 1'b0;
    logic          q_wstrobe_i = 1'b0;
    logic          q_wstrobe_d = 1'b0;
    logic          q_rstrobe_d = 1'b0;
    logic          i_wstrobe, d_wstrobe, d_rstrobe, i_done, d_done, timeout_err;

    int vectors = 0;
    int miscompares = 0;
    bit m_last_d = 1'b0;
    bit m_lock = 1'b0;

    always #5 clk = ~clk;

    qspi_arb dut (
        .clk(clk), .reset(reset), .rom_enable(rom_enable),
        .i_req(i_req), .i_tag(i_tag), .d_push(d_push), .d_pull(d_pull), .d_tag(d_tag),
        .mem_req(mem_req), .mem_i_d(mem_i_d), .mem_mem(mem_mem), .mem_write(mem_write),
        .mem_paddr(mem_paddr), .mem_done(mem_done),
        .q_wstrobe_i(q_wstrobe_i), .q_wstrobe_d(q_wstrobe_d), .q_rstrobe_d(q_rstrobe_d),
        .i_wstrobe(i_wstrobe), .d_wstrobe(d_wstrobe), .d_rstrobe(d_rstrobe),
        .i_done(i_done), .d_done(d_done), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Who should win, from the documented priority rules.
    function automatic int model_pick(input bit ir, input bit ps, input bit pl);
        int dsel;
        dsel = ps ? OWN_PUSH : OWN_PULL;
        if (m_lock && pl) return OWN_PULL;
        if (ir && (ps || pl)) return m_last_d ? OWN_I : dsel;
        if (ps || pl) return dsel;
        if (ir) return OWN_I;
        return OWN_NONE;
    endfunction

    // One full transaction: request in an idle cycle, serve lat cycles (or time out), then GAP.
    task automatic run_txn(input bit ir, input bit ps, input bit pl,
                           input logic [TW-1:0] it, input logic [TW-1:0] dt,
                           input bit rom, input int lat, input bit drop);
        int own;
        int fin;
        bit s_i, s_d, s_r;
        own = model_pick(ir, ps, pl);
        fin = (lat < TMO) ? lat : TMO;
        @(negedge clk);
        i_req = ir; d_push = ps; d_pull = pl; i_tag = it; d_tag = dt;
        rom_enable = rom; mem_done = 1'b0;
        q_wstrobe_i = 1'b0; q_wstrobe_d = 1'b0; q_rstrobe_d = 1'b0;
        #1;
        chk("idle_req", mem_req, 0);
        chk("idle_done", {i_done, d_done, timeout_err}, 0);
        if (own == OWN_I || own == OWN_PULL) m_lock = 1'b0;
        for (int k = 1; k <= fin; k++) begin
            @(negedge clk);
            if (drop) begin
                i_req = 1'b0; d_push = 1'b0; d_pull = 1'b0;
            end
            rom_enable = 1'($urandom_range(0, 1));
            mem_done = (k == lat);
            {s_i, s_d, s_r} = 3'($urandom);
            q_wstrobe_i = s_i; q_wstrobe_d = s_d; q_rstrobe_d = s_r;
            #1;
            chk("mem_req", mem_req, 1);
            chk("mem_paddr", mem_paddr, (own == OWN_I) ? it : dt);
            chk("mem_i_d", mem_i_d, own == OWN_I);
            chk("mem_write", mem_write, own == OWN_PUSH);
            chk("mem_mem", mem_mem, (own == OWN_PUSH) ? 1'b0 : rom);
            chk("i_wstrobe", i_wstrobe, s_i && own == OWN_I);
            chk("d_wstrobe", d_wstrobe, s_d && own == OWN_PULL);
            chk("d_rstrobe", d_rstrobe, s_r && own == OWN_PUSH);
            chk("i_done", i_done, (k == fin) && own == OWN_I);
            chk("d_done", d_done, (k == fin) && own != OWN_I);
            chk("timeout_err", timeout_err, (k == fin) && (lat > TMO));
        end
        m_last_d = (own != OWN_I);
        if (own == OWN_PUSH) m_lock = 1'b1;
        @(negedge clk);
        i_req = 1'b0; d_push = 1'b0; d_pull = 1'b0;
        mem_done = 1'($urandom_range(0, 1));
        {s_i, s_d, s_r} = 3'($urandom);
        q_wstrobe_i = s_i; q_wstrobe_d = s_d; q_rstrobe_d = s_r;
        #1;
        chk("gap_req", mem_req, 0);
        chk("gap_done", {i_done, d_done, timeout_err}, 0);
        chk("gap_strobes", {i_wstrobe, d_wstrobe, d_rstrobe}, 0);
    endtask

    initial begin
        bit [2:0] r;
        #1;
        chk("rst_outputs", {mem_req, mem_i_d, mem_mem, mem_write, i_done, d_done, timeout_err}, 0);
        chk("rst_paddr", mem_paddr, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Lone I fill, done after 20 granted cycles.
        run_txn(1'b1, 1'b0, 1'b0, 20'h12345, 20'h0, 1'b1, 20, 1'b0);
        // Writeback before refill, then the locked refill beats a pending I request.
        run_txn(1'b1, 1'b1, 1'b1, 20'h11111, 20'h00ABC, 1'b0, 6, 1'b0);
        run_txn(1'b1, 1'b0, 1'b1, 20'h22222, 20'h00ABC, 1'b1, 7, 1'b0);
        // Bring last_d back to 0, then alternate D, I, D, I.
        run_txn(1'b1, 1'b0, 1'b0, 20'h33333, 20'h0, 1'b0, 3, 1'b0);
        for (int n = 0; n < 4; n++)
            run_txn(1'b1, 1'b0, 1'b1, 20'h40000 + TW'(n), 20'h50000 + TW'(n), 1'b1, 5 + n, 1'b0);
        // Watchdog expiry, then mem_done arriving exactly at the limit.
        run_txn(1'b1, 1'b0, 1'b0, 20'h0F0F0, 20'h0, 1'b0, 1000, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 20'h0E0E0, 20'h0, 1'b1, TMO, 1'b0);
        // Requester withdraws right after grant.
        run_txn(1'b0, 1'b1, 1'b0, 20'h0, 20'h77777, 1'b1, 9, 1'b1);

        // mem_done with nobody granted is ignored.
        repeat (3) begin
            @(negedge clk);
            mem_done = 1'b1;
            #1;
            chk("idle_ignore_req", mem_req, 0);
            chk("idle_ignore_done", {i_done, d_done, timeout_err}, 0);
        end
        mem_done = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 25; n++) begin
            r = 3'($urandom_range(1, 7));
            run_txn(r[0], r[1], r[2], TW'($urandom), TW'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(1, 30), $urandom_range(0, 3) == 0);
        end

        // Reset asserted mid D_PULL.
        @(negedge clk);
        d_pull = 1'b1; d_tag = 20'h0BEEF; mem_done = 1'b0;
        q_wstrobe_i = 1'b0; q_wstrobe_d = 1'b0; q_rstrobe_d = 1'b0;
        @(negedge clk);
        d_pull = 1'b0;
        #1;
        chk("pull_granted", {mem_req, mem_write, mem_i_d}, 3'b100);
        @(negedge clk);
        q_wstrobe_i = 1'b1; q_wstrobe_d = 1'b1; q_rstrobe_d = 1'b1;
        #1;
        chk("pull_wstrobe", d_wstrobe, 1);
        #1 reset = 1'b0;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_strobes", {i_wstrobe, d_wstrobe, d_rstrobe}, 0);
        mem_done = 1'b1;
        #1;
        chk("arst_done", {i_done, d_done, timeout_err}, 0);
        @(negedge clk);
        mem_done = 1'b0;
        q_wstrobe_i = 1'b0; q_wstrobe_d = 1'b0; q_rstrobe_d = 1'b0;
        reset = 1'b1;
        m_last_d = 1'b0;
        m_lock = 1'b0;
        run_txn(1'b0, 1'b0, 1'b1, 20'h0, 20'h0CAFE, 1'b1, 4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qspi_arb.md
Name: qspi_arb

Overview:
- Arbitrates the single QSPI line-transfer engine between three requesters: I-cache line fill, D-cache line writeback (push) and D-cache line fill (pull).
- Latches the winning tag and direction, then drives one clean transaction to qspi.
- Steers the qspi data strobes back to the owning cache and pulses a per-cache done.
- Includes a timeout watchdog so a hung flash/PSRAM transfer cannot deadlock the core.
- Sits in vc between icache/dcache and qspi, replacing the combinational req/ctag muxing.

Parameters:
- PA, 22, physical address width
- LINE_LENGTH, 4, cache line bytes; tag width is PA-$clog2(LINE_LENGTH)
- TIMEOUT, 255, cycles a granted transfer may wait for mem_done before abort; counter width $clog2(TIMEOUT+1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rom_enable  in  1  ROM window enable from execute
- i_req  in  1  I-cache pull request (ifetch & i_pull)
- i_tag  in  PA-$clog2(LINE_LENGTH)  I-cache line tag
- d_push  in  1  D-cache writeback request (already gated with rstrobe|wmask and !io_access)
- d_pull  in  1  D-cache fill request (same gating)
- d_tag  in  PA-$clog2(LINE_LENGTH)  D-cache line tag
- mem_req  out  1  transaction request to qspi
- mem_i_d  out  1  1 = instruction owner
- mem_mem  out  1  ROM/mem select to qspi
- mem_write  out  1  1 = line write
- mem_paddr  out  PA-$clog2(LINE_LENGTH)  latched line tag
- mem_done  in  1  qspi one-cycle pulse at end of line
- q_wstrobe_i  in  1  qspi fill strobe, I side
- q_wstrobe_d  in  1  qspi fill strobe, D side
- q_rstrobe_d  in  1  qspi writeback read strobe
- i_wstrobe  out  1  fill strobe to icache
- d_wstrobe  out  1  fill strobe to dcache
- d_rstrobe  out  1  writeback strobe to dcache
- i_done  out  1  pulse: I fill complete
- d_done  out  1  pulse: D push/pull complete
- timeout_err  out  1  pulse: transfer aborted by watchdog

Behaviour:
- States: IDLE, I_FILL, D_PUSH, D_PULL, GAP.
- Reset: state=IDLE; all outputs 0; last_d=0, d_lock=0, counter=0.
- Request sampling:
  - IDLE samples requests in cycle N.
  - On grant, the state, mem_paddr, mem_write and mem_i_d are registered; mem_req=1 from cycle N+1.
  - mem_req stays high until mem_done or timeout.
- Priority in IDLE:
  - d_lock=1 and d_pull → D_PULL.
  - Else d_push is served before d_pull; writeback always precedes refill.
  - Between I and D: round-robin on last_d.
    - Both pending and last_d=0 → D.
    - Both pending and last_d=1 → I.
  - Single requester wins immediately.
- Grant encodings:
  - I_FILL: mem_write=0, mem_i_d=1, mem_mem=rom_enable.
  - D_PUSH: mem_write=1, mem_i_d=0, mem_mem=0.
  - D_PULL: mem_write=0, mem_i_d=0, mem_mem=rom_enable.
  - rom_enable is sampled at grant.
- Strobe steering:
  - Combinational and gated by state.
  - i_wstrobe=q_wstrobe_i only in I_FILL.
  - d_wstrobe=q_wstrobe_d only in D_PULL.
  - d_rstrobe=q_rstrobe_d only in D_PUSH.
  - Strobes arriving in any other state are dropped.
- On mem_done:
  - Pulse the matching i_done/d_done in the same cycle as mem_done.
  - Drop mem_req next cycle and go to GAP.
  - last_d updates: 1 after D_PUSH or D_PULL, 0 after I_FILL.
  - d_lock is set on D_PUSH completion and cleared on any D_PULL grant or I grant.
- GAP: one cycle with mem_req=0, then IDLE. Consecutive transactions are therefore separated by ≥2 cycles of mem_req low, which gives qspi its CS deassert.
- Watchdog:
  - Counter clears at grant and increments each granted cycle.
  - On reaching TIMEOUT without mem_done: pulse timeout_err, pulse the owner's done, drop mem_req, go to GAP.
  - mem_done in the same cycle the counter reaches TIMEOUT wins; timeout_err is not raised.
- Request withdrawal: if a requester drops its request mid-transfer, the transaction still completes (qspi cannot be cut mid-line) and done is still pulsed.
- Reset asserted mid-transfer: immediate return to IDLE, mem_req=0, strobes masked.
- mem_done in IDLE/GAP is ignored.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, I_FILL, D_PUSH, D_PULL, GAP, 3 bits);
  - the tag-width localparam TAGW=PA-$clog2(LINE_LENGTH).
- One natural sub-module: qspi_arb_wdog (loadable timeout counter with clear/expire outputs).

Test Plan:
- Lone i_req, i_tag=0x12345:
  - mem_req rises 1 cycle later with mem_paddr=0x12345, mem_i_d=1, mem_write=0.
  - mem_done after 20 cycles → i_done pulse; mem_req low ≥2 cycles.
- d_push and d_pull together, d_tag=0x00ABC:
  - D_PUSH first (mem_write=1); q_rstrobe_d reaches d_rstrobe only.
  - Then D_PULL wins even with i_req pending (d_lock).
- i_req and d_pull held continuously with last_d=0:
  - Grants alternate D, I, D, I across 4 transfers.
- Strobes outside the owner's state are dropped:
  - q_wstrobe_d pulsed during I_FILL → d_wstrobe stays 0.
  - q_wstrobe_i during I_FILL → i_wstrobe follows.
- TIMEOUT=255 with no mem_done:
  - timeout_err and i_done pulse at granted cycle 255; return to IDLE via GAP.
  - Repeat with mem_done on cycle 255 → no timeout_err.
- reset low during D_PULL:
  - mem_req=0 and all strobes/dones 0 asynchronously.
  - After release, a new d_pull is granted normally.
